pcie_axi_sram_rd_pipe: RTL
==========================

// Module: pcie_axi_sram_rd_pipe
// PURPOSE
//  Parametrised AXI read slave serving bursts from a single-port synchronous SRAM.
//  Sits between the PCIe AXI read master and the local SRAM.
//  Keeps SRAM reads pipelined ahead through a credit-limited prefetch FIFO, so it
//  sustains 1 beat/clk while rready stays high.
//  Adds FIXED/INCR/WRAP bursts, configurable SRAM latency and SLVERR/DECERR responses.
// PARAMETERS
//  DATA_W     256  AXI/SRAM data width, bits (power of 2, >=32)
//  ADDR_W     64   AXI address width
//  SRAM_AW    10   SRAM word-address width; depth = 2**SRAM_AW words
//  LEN_W      12   arlen width; burst beats = arlen+1
//  SRAM_LAT   1    cycles from sram_ren to valid sram_rdata (1..4)
//  FIFO_DEPTH 4    prefetch FIFO entries (power of 2, >= SRAM_LAT+2)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        synchronous active-low reset
//  axi_arvalid  in   1        read address valid
//  axi_araddr   in   ADDR_W   byte address
//  axi_arlen    in   LEN_W    beats-1
//  axi_arsize   in   3        bytes/beat = 2**arsize
//  axi_arburst  in   2        0 FIXED, 1 INCR, 2 WRAP, 3 reserved
//  axi_arready  out  1        address accept
//  axi_rvalid   out  1        read data valid
//  axi_rdata    out  DATA_W   read data (0 on error beats)
//  axi_rresp    out  2        0 OKAY, 2 SLVERR, 3 DECERR
//  axi_rlast    out  1        last beat of burst
//  axi_rready   in   1        read data ready
//  sram_ren     out  1        SRAM read enable (one word per cycle)
//  sram_raddr   out  SRAM_AW  SRAM word address
//  sram_rdata   in   DATA_W   SRAM data, valid SRAM_LAT cycles after sram_ren
// BEHAVIOUR
//  Reset (rst_n low at posedge): state=IDLE; FIFO, counters and in-flight tags cleared.
//   arready, rvalid, rlast, sram_ren = 0; rresp = 0; rdata = 0.
//   arready is held 0 while rst_n is low.
//   SRAM data that returns after a mid-burst reset is discarded; no stale beat is ever emitted.
//  Word index W = araddr >> log2(DATA_W/8); B = arlen+1 beats.
//  FSM IDLE -> ISSUE -> DRAIN -> IDLE; IDLE -> ERR -> IDLE. One burst outstanding at a time.
//  IDLE: arready=1. On arvalid&arready, latch the request and classify it. Error class order:
//   SLVERR: arsize != log2(DATA_W/8); arburst=3; WRAP with B not in {2,4,8,16}.
//   DECERR: araddr bits above SRAM_AW+log2(DATA_W/8) nonzero; INCR with W+B > 2**SRAM_AW.
//   If a request is both SLVERR and DECERR, report SLVERR.
//   Error -> ERR; otherwise -> ISSUE. arready is 0 in every state except IDLE.
//  Address sequence per beat i:
//   FIXED: W. INCR: W+i. WRAP: (W & ~(B-1)) | ((W+i) & (B-1)).
//   Unaligned WRAP start is legal.
//  ISSUE: sram_ren=1 in any cycle where issued<B and (fifo_count+in_flight) < FIFO_DEPTH.
//   First sram_ren comes in the cycle after the AR handshake. Go to DRAIN once issued==B.
//  Return path: SRAM_LAT-deep valid shift-register tag follows each ren.
//   When a tag emerges, sram_rdata is written into the FIFO.
//   FIFO never overflows, by the credit rule above.
//  R output: rvalid = FIFO not empty, driven from registered FIFO head.
//   rresp=OKAY; rlast=1 on beat B-1 only.
//   Beat popped on rvalid&rready; rdata/rresp/rlast are held stable while rvalid&!rready.
//   Simultaneous push and pop in one cycle is legal; count is unchanged.
//  Latency: AR handshake at cycle T -> first rvalid at T+SRAM_LAT+2.
//   Then 1 beat/cycle with rready=1.
//  DRAIN: no reads; -> IDLE in the cycle after the rlast beat pops, with arready=1 in that IDLE cycle.
//  ERR: emits B beats with rvalid=1, rdata=0, rresp=SLVERR/DECERR and rlast on beat B-1.
//   No sram_ren is issued. -> IDLE after the last pop.
//  Counters are LEN_W+1 bits wide, so arlen=all-ones (B=2**LEN_W) does not overflow.
//  SRAM address arithmetic is modulo 2**SRAM_AW; only WRAP/FIXED can rely on this, since INCR overflow is DECERR.
// TESTING
//  INCR araddr=0x40 (DATA_W=256 => W=2), arlen=3, rready=1 -> rvalid T+3..T+6.
//   Data sram[2..5], OKAY, rlast on 4th beat only.
//  WRAP W=6, arlen=3 -> read order sram[6],[7],[4],[5]; FIXED W=9, arlen=2 -> sram[9] x3.
//  INCR arlen=15, rready toggling 1,0,0,1... -> no beat lost or duplicated; data stable while stalled.
//   fifo_count+in_flight never exceeds FIFO_DEPTH.
//  W=1020, arlen=7 -> 8 DECERR beats, rdata=0, zero sram_ren.
//   arsize=3 -> SLVERR beats; next OKAY burst is accepted normally.
//  rst_n low for 1 cycle mid-burst (beat 2 of 8) -> next cycle all outputs 0.
//   A following burst returns correct data only, with no stale beats.
//  SRAM_LAT=3, FIFO_DEPTH=8 build: arlen=31, rready=1 -> first rvalid at T+5, then 32 back-to-back beats.

Source files
------------

// File: rtl/pcie_axi_sram_rd_pipe_if.sv
// AXI read-channel bundle (AR + R) between the PCIe read master and the SRAM read pipe.
interface pcie_axi_sram_rd_pipe_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 12
);
  logic              axi_arvalid;
  logic [ADDR_W-1:0] axi_araddr;
  logic [LEN_W-1:0]  axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;
  logic              axi_arready;
  logic              axi_rvalid;
  logic [DATA_W-1:0] axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rlast;
  logic              axi_rready;

  modport master (
    output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_rready,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast
  );

  modport slave (
    input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_rready,
    output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast
  );
endinterface

// File: rtl/pcie_axi_sram_rd_pipe.sv
// AXI read slave serving FIXED/INCR/WRAP bursts from a single-port synchronous SRAM,
// prefetching through a credit-limited FIFO to sustain one beat per clock.
module pcie_axi_sram_rd_pipe #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 64,
  parameter int SRAM_AW    = 10,
  parameter int LEN_W      = 12,
  parameter int SRAM_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pcie_axi_sram_rd_pipe_if.slave axi,
  output logic                sram_ren,
  output logic [SRAM_AW-1:0]  sram_raddr,
  input  logic [DATA_W-1:0]   sram_rdata
);
  localparam int OFF   = $clog2(DATA_W / 8);
  localparam int CNT_W = LEN_W + 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = ((SRAM_AW > CNT_W) ? SRAM_AW : CNT_W) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ERR} state_t;
  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD} burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  state_t             state, next_state;
  logic [SRAM_AW-1:0] word;
  logic [CNT_W-1:0]   beats, issued, popped;
  burst_t             burst;
  logic [1:0]         err_resp;

  logic [SRAM_LAT-1:0] tag;
  logic [SRAM_LAT:0]   tag_shift;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         count, in_flight;
  logic [PW+1:0]       occupancy;

  logic             accept, pop, fifo_pop, push, beat_last;
  logic [CNT_W-1:0] req_beats;
  logic [CW-1:0]    req_end;
  burst_t           req_burst;
  logic             req_wrap_ok, req_slverr, req_decerr;
  logic [SRAM_AW-1:0] offset, wrap_mask;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^axi.axi_araddr[OFF-1:0];

  // Request classification; SLVERR takes priority over DECERR at the latch point.
  always_comb begin
    req_burst   = burst_t'(axi.axi_arburst);
    req_beats   = {1'b0, axi.axi_arlen} + CNT_W'(1);
    req_end     = CW'(axi.axi_araddr[OFF +: SRAM_AW]) + CW'(req_beats);
    req_wrap_ok = (req_beats == CNT_W'(2)) || (req_beats == CNT_W'(4)) ||
                  (req_beats == CNT_W'(8)) || (req_beats == CNT_W'(16));
    req_slverr  = (axi.axi_arsize != 3'(OFF)) || (req_burst == BURST_RSVD) ||
                  ((req_burst == BURST_WRAP) && !req_wrap_ok);
    req_decerr  = (|axi.axi_araddr[ADDR_W-1:SRAM_AW+OFF]) ||
                  ((req_burst == BURST_INCR) && (req_end > (CW'(1) << SRAM_AW)));
  end

  assign accept    = axi.axi_arvalid && axi.axi_arready;
  assign pop       = axi.axi_rvalid && axi.axi_rready;
  assign fifo_pop  = pop && (state != ERR);
  assign push      = tag[SRAM_LAT-1];
  assign beat_last = (popped == beats - CNT_W'(1));
  assign tag_shift = {tag, sram_ren};

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (req_slverr || req_decerr) ? ERR : ISSUE;
      ISSUE:   if (sram_ren && ((issued + CNT_W'(1)) == beats)) next_state = DRAIN;
      DRAIN:   if (pop && axi.axi_rlast) next_state = IDLE;
      ERR:     if (pop && axi.axi_rlast) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    axi.axi_arready = rst_n && (state == IDLE);

    in_flight = '0;
    for (int i = 0; i < SRAM_LAT; i++) in_flight = in_flight + (PW+1)'(tag[i]);
    occupancy = (PW+2)'(count) + (PW+2)'(in_flight);

    // A read is only launched when its data is guaranteed a FIFO slot on return.
    sram_ren  = (state == ISSUE) && (issued < beats) && (occupancy < (PW+2)'(FIFO_DEPTH));
    offset    = SRAM_AW'(issued);
    wrap_mask = SRAM_AW'(beats - CNT_W'(1));
    case (burst)
      BURST_INCR: sram_raddr = word + offset;
      BURST_WRAP: sram_raddr = (word & ~wrap_mask) | ((word + offset) & wrap_mask);
      default:    sram_raddr = word;
    endcase
    if (!sram_ren) sram_raddr = '0;

    axi.axi_rvalid = (state == ERR) || (count != '0);
    axi.axi_rlast  = axi.axi_rvalid && beat_last;
    axi.axi_rresp  = (state == ERR) ? err_resp : RESP_OKAY;
    axi.axi_rdata  = ((state != ERR) && (count != '0)) ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word     <= '0;
      beats    <= '0;
      burst    <= BURST_FIXED;
      err_resp <= RESP_OKAY;
      issued   <= '0;
      popped   <= '0;
      tag      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      // Tags cleared by reset make any SRAM data still in flight get dropped.
      tag <= tag_shift[SRAM_LAT-1:0];
      if (accept) begin
        word     <= axi.axi_araddr[OFF +: SRAM_AW];
        beats    <= req_beats;
        burst    <= req_burst;
        err_resp <= req_slverr ? RESP_SLVERR : RESP_DECERR;
        issued   <= '0;
        popped   <= '0;
      end else begin
        if (sram_ren) issued <= issued + CNT_W'(1);
        if (pop)      popped <= popped + CNT_W'(1);
      end
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, fifo_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the cleared count keeps unwritten entries unobservable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sram_rdata;
  end
endmodule
